// File: rtl/bpf_level_pkg.sv
// Shared types and helpers for the bandpass-filter level detector (optional clip counting: BPF_LEVEL_CLIP_EN).
// Pure definitions; no latency or backpressure of its own.
package bpf_level_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_WIN_LOG2 = 10;
  localparam int DEF_FS_POS   = (1 << (DEF_DATA_W - 1)) - 1;
  localparam int DEF_FS_NEG   = -(1 << (DEF_DATA_W - 1));

  // Accumulator never overflows: 2^win_log2 samples of at most 2^(data_w-1)-1.
  function automatic int acc_width(input int data_w, input int win_log2);
    return data_w + win_log2;
  endfunction

  // |x| with the most negative code folded onto positive full scale.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] x, input int w);
    logic signed [31:0] fs_neg;
    fs_neg = -(32'sd1 <<< (w - 1));
    if (x == fs_neg) return 32'(-(fs_neg + 32'sd1));
    if (x < 32'sd0) return 32'(-x);
    return 32'(x);
  endfunction

endpackage

// File: rtl/bpf_level_detector_if.sv
// Sample stream in, window result out (m_clip_cnt exists only with BPF_LEVEL_CLIP_EN).
// slave = detector side, master = producer/consumer side.
interface bpf_level_detector_if #(
  parameter int DATA_W = 16
`ifdef BPF_LEVEL_CLIP_EN
  ,
  parameter int WIN_LOG2 = 10
`endif
) ();

  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] s_data;
  logic                     m_valid;
  logic                     m_ready;
  logic [DATA_W-1:0]        m_peak;
  logic [DATA_W-1:0]        m_mean;
`ifdef BPF_LEVEL_CLIP_EN
  logic [WIN_LOG2:0]        m_clip_cnt;
`endif

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_peak, m_mean
`ifdef BPF_LEVEL_CLIP_EN
    , output m_clip_cnt
`endif
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_peak, m_mean
`ifdef BPF_LEVEL_CLIP_EN
    , input m_clip_cnt
`endif
  );

endinterface

// File: rtl/bpf_abs_sat.sv
// Stage-1 register: saturated |sample|, last-of-window flag and (BPF_LEVEL_CLIP_EN) full-scale flag.
// 1-cycle latency; no backpressure, loads whenever in_vld is high.
module bpf_abs_sat
  import bpf_level_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  input  logic signed [DATA_W-1:0] in_dat,
  input  logic                     in_last,
  output logic                     out_vld,
  output logic [DATA_W-1:0]        out_abs,
  output logic                     out_last
`ifdef BPF_LEVEL_CLIP_EN
  ,
  output logic                     out_clip
`endif
);

`ifdef BPF_LEVEL_CLIP_EN
  localparam logic signed [DATA_W-1:0] FS_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] FS_NEG = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_abs  <= '0;
      out_last <= 1'b0;
`ifdef BPF_LEVEL_CLIP_EN
      out_clip <= 1'b0;
`endif
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_abs  <= DATA_W'(abs_sat(32'(in_dat), DATA_W));
        out_last <= in_last;
`ifdef BPF_LEVEL_CLIP_EN
        out_clip <= (in_dat == FS_POS) || (in_dat == FS_NEG);
`endif
      end
    end
  end

endmodule

// File: rtl/bpf_level_detector.sv
// Peak and mean |sample| over 2^WIN_LOG2 samples, one result per window; clip count with BPF_LEVEL_CLIP_EN.
// Result valid 2 cycles after last accept; s_ready low from then until the result handshake.
module bpf_level_detector
  import bpf_level_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WIN_LOG2 = DEF_WIN_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  bpf_level_detector_if.slave   bus,
  output logic                  busy
);

  localparam int ACC_W = acc_width(DATA_W, WIN_LOG2);

  state_t              state;
  logic [WIN_LOG2-1:0] cnt;
  logic [ACC_W-1:0]    acc;
  logic [DATA_W-1:0]   peak;
  logic                s_ready_q;
  logic                m_valid_q;
  logic [DATA_W-1:0]   m_peak_q;
  logic [DATA_W-1:0]   m_mean_q;

  logic                accept;
  logic                last_in;
  logic                s1_vld;
  logic                s1_last;
  logic [DATA_W-1:0]   s1_abs;
  logic [ACC_W-1:0]    acc_nxt;
  logic [DATA_W-1:0]   peak_nxt;

  assign accept   = bus.s_valid && s_ready_q;
  assign last_in  = (cnt == {WIN_LOG2{1'b1}});
  assign acc_nxt  = acc + ACC_W'(s1_abs);
  assign peak_nxt = (s1_abs > peak) ? s1_abs : peak;

`ifdef BPF_LEVEL_CLIP_EN
  logic                s1_clip;
  logic [WIN_LOG2:0]   clip_cnt;
  logic [WIN_LOG2:0]   clip_nxt;
  logic [WIN_LOG2:0]   m_clip_q;

  assign clip_nxt       = clip_cnt + (WIN_LOG2 + 1)'(s1_clip);
  assign bus.m_clip_cnt = m_clip_q;
`endif

  bpf_abs_sat #(.DATA_W(DATA_W)) u_stage1 (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (accept),
    .in_dat   (bus.s_data),
    .in_last  (last_in),
    .out_vld  (s1_vld),
    .out_abs  (s1_abs),
    .out_last (s1_last)
`ifdef BPF_LEVEL_CLIP_EN
    ,
    .out_clip (s1_clip)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      cnt       <= '0;
      acc       <= '0;
      peak      <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_peak_q  <= '0;
      m_mean_q  <= '0;
`ifdef BPF_LEVEL_CLIP_EN
      clip_cnt  <= '0;
      m_clip_q  <= '0;
`endif
    end else begin
      if (s1_vld) begin
        acc      <= acc_nxt;
        peak     <= peak_nxt;
`ifdef BPF_LEVEL_CLIP_EN
        clip_cnt <= clip_nxt;
`endif
      end
      case (state)
        ACCUM: begin
          if (accept) begin
            cnt <= cnt + WIN_LOG2'(1);
            if (last_in) begin
              s_ready_q <= 1'b0;
              state     <= DRAIN;
            end
          end
        end
        // Stage 1 holds the window's last sample here; fold it straight into the result.
        DRAIN: begin
          if (s1_vld && s1_last) begin
            m_peak_q  <= peak_nxt;
            m_mean_q  <= acc_nxt[ACC_W-1:WIN_LOG2];
            m_valid_q <= 1'b1;
            acc       <= '0;
            peak      <= '0;
`ifdef BPF_LEVEL_CLIP_EN
            m_clip_q  <= clip_nxt;
            clip_cnt  <= '0;
`endif
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_peak  = m_peak_q;
  assign bus.m_mean  = m_mean_q;
  assign busy        = (cnt != '0) || (state == DRAIN);

endmodule

// File: tb/tb_bpf_level_detector.sv
// Directed bench for bpf_level_detector: window table plus hold and reset-abort sequences.
// Clip count is checked only when built with BPF_LEVEL_CLIP_EN.
module tb_bpf_level_detector;
  import bpf_level_pkg::*;

  localparam int DW = 16;
  localparam int WL = 10;
  localparam int N  = 1 << WL;

  typedef enum int {P_CONST, P_RAMP, P_ALT, P_PAR} pat_e;

  typedef struct {
    pat_e pat;
    int   val;
    int   pct;
    int   exp_peak;
    int   exp_mean;
    int   exp_clip;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   checks = 0;
  int   failures = 0;

  bpf_level_detector_if #(
    .DATA_W(DW)
`ifdef BPF_LEVEL_CLIP_EN
    ,
    .WIN_LOG2(WL)
`endif
  ) bus ();

  bpf_level_detector #(.DATA_W(DW), .WIN_LOG2(WL)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sample_val(input pat_e p, input int val, input int i);
    case (p)
      P_CONST: return val;
      P_RAMP:  return i - 512;
      P_ALT:   return (i % 2 == 0) ? DEF_FS_POS : DEF_FS_NEG;
      P_PAR:   return (i % 2 == 1) ? val : 0;
      default: return 0;
    endcase
  endfunction

  // Offers samples at pct% valid density until n_samp have been accepted (bounded).
  task automatic feed(input string tag, input pat_e p, input int val, input int pct,
                      input int n_samp, output int got);
    int   i = 0;
    int   cyc = 0;
    logic take;
    bit   busy_bad = 0;
    bit   mval_bad = 0;
    while (i < n_samp && cyc < 20 * N) begin
      @(negedge clk);
      if (i > 0 && busy !== 1'b1) busy_bad = 1;
      if (bus.m_valid !== 1'b0) mval_bad = 1;
      bus.s_valid = (pct >= 100) || ($urandom_range(0, 99) < pct);
      bus.s_data  = bus.s_valid ? 16'(sample_val(p, val, i)) : 16'sh0309;
      take = bus.s_valid && bus.s_ready;
      @(posedge clk);
      if (take) i++;
      cyc++;
    end
    got = i;
    chk({tag, ".busy_accum"}, 32'(busy_bad), 0);
    chk({tag, ".no_early_result"}, 32'(mval_bad), 0);
  endtask

  task automatic window(input vec_t v, input string tag, input bit hold);
    int got;
    bit bad;
    bus.m_ready = !hold;
    feed(tag, v.pat, v.val, v.pct, N, got);
    chk({tag, ".accepts"}, got, N);
    @(negedge clk);
    // Junk offered during DRAIN/HOLD must be ignored.
    bus.s_valid = 1'b1;
    bus.s_data  = 16'sd30000;
    chk({tag, ".drain_m_valid"}, 32'(bus.m_valid), 0);
    chk({tag, ".drain_s_ready"}, 32'(bus.s_ready), 0);
    chk({tag, ".drain_busy"}, 32'(busy), 1);
    @(negedge clk);
    chk({tag, ".m_valid_lat2"}, 32'(bus.m_valid), 1);
    chk({tag, ".hold_busy"}, 32'(busy), 0);
    chk({tag, ".hold_s_ready"}, 32'(bus.s_ready), 0);
    chk({tag, ".peak"}, 32'(bus.m_peak), v.exp_peak);
    chk({tag, ".mean"}, 32'(bus.m_mean), v.exp_mean);
`ifdef BPF_LEVEL_CLIP_EN
    chk({tag, ".clip"}, 32'(bus.m_clip_cnt), v.exp_clip);
`endif
    if (hold) begin
      bad = 0;
      repeat (50) begin
        @(negedge clk);
        if (bus.m_valid !== 1'b1 || bus.s_ready !== 1'b0 ||
            bus.m_peak !== 16'(v.exp_peak) || bus.m_mean !== 16'(v.exp_mean)) bad = 1;
      end
      chk({tag, ".hold_stable"}, 32'(bad), 0);
      bus.m_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, ".after_hs_m_valid"}, 32'(bus.m_valid), 0);
    chk({tag, ".after_hs_s_ready"}, 32'(bus.s_ready), 1);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
  endtask

  initial begin
    vec_t vecs[7];
    int   got;
    vecs[0] = '{P_CONST, 1000, 100, 1000, 1000, 0};
    vecs[1] = '{P_RAMP, 0, 100, 512, 256, 0};
    vecs[2] = '{P_ALT, 0, 100, 32767, 32767, 1024};
    vecs[3] = '{P_CONST, -7, 50, 7, 7, 0};
    vecs[4] = '{P_PAR, 3, 100, 3, 1, 0};
    vecs[5] = '{P_CONST, -32768, 100, 32767, 32767, 1024};
    vecs[6] = '{P_CONST, 0, 70, 0, 0, 0};

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset.s_ready", 32'(bus.s_ready), 1);
    chk("reset.m_valid", 32'(bus.m_valid), 0);
    chk("reset.m_peak", 32'(bus.m_peak), 0);
    chk("reset.m_mean", 32'(bus.m_mean), 0);
    chk("reset.busy", 32'(busy), 0);
`ifdef BPF_LEVEL_CLIP_EN
    chk("reset.clip", 32'(bus.m_clip_cnt), 0);
`endif

    for (int k = 0; k < 7; k++) window(vecs[k], $sformatf("v%0d", k), 1'b0);

    window('{P_CONST, 4242, 100, 4242, 4242, 0}, "hold50", 1'b1);

    feed("abort", P_CONST, 2000, 100, 500, got);
    chk("abort.partial_accepts", got, 500);
    @(negedge clk);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.s_ready", 32'(bus.s_ready), 1);
    chk("abort.m_valid", 32'(bus.m_valid), 0);
    chk("abort.busy", 32'(busy), 0);
    chk("abort.m_peak", 32'(bus.m_peak), 0);
    chk("abort.m_mean", 32'(bus.m_mean), 0);
    window('{P_CONST, 300, 100, 300, 300, 0}, "after_abort", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
